// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS31 constants and checker FSM encodings
package prbs_pkg;

  localparam int PRBS31_WIDTH = 31;
  localparam logic [PRBS31_WIDTH-1:0] PRBS31_POLY = 31'h10000001;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - combinational multi-bit LFSR step (Fibonacci or Galois)
// Produces the next DATA_WIDTH output bits (MSB = earliest) and the advanced state.
module lfsr #(
  parameter int                    LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] POLY       = 31'h10000001,
  parameter bit                    FIBONACCI  = 1'b1,
  parameter bit                    REVERSE    = 1'b0,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [LFSR_WIDTH-1:0] state_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [LFSR_WIDTH-1:0] state_o
);

  // POLY bit 0 is the +1 term, which taps the oldest bit in a left-shifting register
  localparam logic [LFSR_WIDTH-1:0] TAPS = {POLY[0], POLY[LFSR_WIDTH-1:1]};

  logic [LFSR_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] bits;
  logic                  b;

  always_comb begin
    s    = state_i;
    bits = '0;
    b    = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (FIBONACCI) begin
        b = (^(s & TAPS)) ^ data_i[DATA_WIDTH-1-i];
        s = {s[LFSR_WIDTH-2:0], b};
      end else begin
        b = s[LFSR_WIDTH-1] ^ data_i[DATA_WIDTH-1-i];
        s = {s[LFSR_WIDTH-2:0], 1'b0} ^ (b ? POLY : '0);
      end
      bits[DATA_WIDTH-1-i] = b;
    end
    state_o = s;
  end

  always_comb begin
    data_o = bits;
    if (REVERSE) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        data_o[j] = bits[DATA_WIDTH-1-j];
      end
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 checker with lock FSM and error counter
// Define PRBS_CHK_BIT_ERR_EN to count bit errors instead of errored words.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_COUNT  = 4,
  parameter int ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_valid,
  input  logic                     err_clr,
  output logic                     locked,
  output logic                     word_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int FILL_WORDS = (PRBS31_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FILL_W     = $clog2(FILL_WORDS + 1);
  localparam int MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W     = $clog2(UNLOCK_COUNT + 1);
  localparam int CW         = ERR_CNT_WIDTH + 1;

  chk_state_e               fsm_q, fsm_d;
  logic [PRBS31_WIDTH-1:0]  state_q, state_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [MATCH_W-1:0]       match_q, match_d;
  logic [MISS_W-1:0]        miss_q, miss_d;
  logic                     word_err_q, word_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0]    pred;
  logic [PRBS31_WIDTH-1:0]  state_next;
  logic [PRBS31_WIDTH-1:0]  shift_in;
  logic [DATA_WIDTH-1:0]    diff;
  logic                     mismatch;
  logic                     seed_match;
  logic                     inc_en;
  logic [CW-1:0]            inc;
  logic [CW-1:0]            base;
  logic [CW-1:0]            sum;

  lfsr #(
    .LFSR_WIDTH (PRBS31_WIDTH),
    .POLY       (PRBS31_POLY),
    .FIBONACCI  (1'b1),
    .REVERSE    (1'b0),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pred (
    .state_i (state_q),
    .data_i  ({DATA_WIDTH{1'b0}}),
    .data_o  (pred),
    .state_o (state_next)
  );

  // Self-seeding: the newest received bits become the low end of the state
  if (DATA_WIDTH >= PRBS31_WIDTH) begin : g_wide
    assign shift_in = data_in[PRBS31_WIDTH-1:0];
  end else begin : g_narrow
    assign shift_in = {state_q[PRBS31_WIDTH-DATA_WIDTH-1:0], data_in};
  end

  assign diff       = data_in ^ pred;
  assign mismatch   = |diff;
  assign seed_match = !mismatch && (state_q != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= ST_SEED;
      state_q     <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      word_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      word_err_q  <= word_err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (data_valid) begin
      unique case (fsm_q)
        ST_SEED:
          if (fill_q == FILL_W'(FILL_WORDS - 1)) fsm_d = ST_VERIFY;
        ST_VERIFY:
          if (seed_match && match_q == MATCH_W'(LOCK_COUNT - 1)) fsm_d = ST_LOCKED;
        ST_LOCKED:
          if (mismatch && miss_q == MISS_W'(UNLOCK_COUNT - 1)) fsm_d = ST_SEED;
        default: fsm_d = ST_SEED;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    match_d    = match_q;
    miss_d     = miss_q;
    word_err_d = 1'b0;
    inc_en     = 1'b0;
    if (data_valid) begin
      unique case (fsm_q)
        ST_SEED: begin
          state_d = shift_in;
          fill_d  = (fill_q == FILL_W'(FILL_WORDS - 1)) ? '0 : fill_q + 1'b1;
          match_d = '0;
        end
        ST_VERIFY: begin
          state_d = shift_in;
          if (seed_match) begin
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d = state_next;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          state_d = state_next;
          if (mismatch) begin
            word_err_d = 1'b1;
            inc_en     = 1'b1;
            if (miss_q == MISS_W'(UNLOCK_COUNT - 1)) begin
              miss_d = '0;
              fill_d = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = '0;
          fill_d  = '0;
        end
      endcase
    end
  end

  // Clear happens before the add, so a simultaneous error leaves exactly the increment
  always_comb begin
    inc = '0;
    if (inc_en) begin
`ifdef PRBS_CHK_BIT_ERR_EN
      for (int i = 0; i < DATA_WIDTH; i++) begin
        inc = inc + CW'(diff[i]);
      end
`else
      inc = CW'(1);
`endif
    end
    base        = err_clr ? '0 : {1'b0, err_count_q};
    sum         = base + inc;
    err_count_d = sum[CW-1] ? '1 : sum[ERR_CNT_WIDTH-1:0];
  end

  assign locked    = (fsm_q == ST_LOCKED);
  assign word_err  = word_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - scoreboard bench for prbs31_checker (directed PRBS31 vectors)
module tb_prbs31_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       err_clr;
  logic       locked;
  logic       word_err;
  logic [3:0] err_count;

  int tests  = 0;
  int failed = 0;

`ifdef PRBS_CHK_BIT_ERR_EN
  localparam int FF_INC = 8;
`else
  localparam int FF_INC = 1;
`endif

  typedef struct {
    logic       lk;
    logic       we;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [30:0] g;
  logic [7:0]  w;

  always #5 clk = ~clk;

  prbs31_checker #(
    .DATA_WIDTH    (8),
    .LOCK_COUNT    (8),
    .UNLOCK_COUNT  (4),
    .ERR_CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .err_clr    (err_clr),
    .locked     (locked),
    .word_err   (word_err),
    .err_count  (err_count)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (locked !== mon_e.lk || word_err !== mon_e.we || err_count !== mon_e.cnt) begin
        failed++;
        $display("FAIL %s: got locked=%0b word_err=%0b err_count=%0d, want locked=%0b word_err=%0b err_count=%0d",
                 mon_e.name, locked, word_err, err_count, mon_e.lk, mon_e.we, mon_e.cnt);
      end
    end
  end

  // Reference PRBS31 generator: x^31+x^28+1, one bit at a time, MSB-first words
  task automatic gen(output logic [7:0] word);
    logic nb;
    word = '0;
    for (int i = 0; i < 8; i++) begin
      nb   = g[30] ^ g[27];
      g    = {g[29:0], nb};
      word = {word[6:0], nb};
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c,
                      input logic elk, input logic ewe, input int ecnt, input string nm);
    exp_t e;
    rst        = r;
    data_valid = v;
    data_in    = d;
    err_clr    = c;
    @(posedge clk);
    e.lk   = elk;
    e.we   = ewe;
    e.cnt  = ecnt[3:0];
    e.name = nm;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    err_clr    = 1'b0;
    g          = 31'h7FFFFFFF;
    #2;

    step(0, 0, 8'h00, 0, 0, 0, 0, "reset0");
    step(0, 1, 8'h5A, 0, 0, 0, 0, "reset1");

    // 4 seed words + 8 matching words
    for (int k = 1; k <= 12; k++) begin
      gen(w);
      step(1, 1, w, 0, k == 12, 0, 0, "acquire");
    end
    for (int k = 0; k < 2; k++) begin
      gen(w);
      step(1, 1, w, 0, 1, 0, 0, "locked_clean");
    end

    gen(w);
    step(1, 1, w ^ 8'h01, 0, 1, 1, 1, "bit0_err");
    gen(w);
    step(1, 1, w, 0, 1, 0, 1, "after_bit0");
    step(1, 0, 8'hFF, 0, 1, 0, 1, "gap_hold0");
    step(1, 0, 8'h00, 0, 1, 0, 1, "gap_hold1");

    gen(w);
    step(1, 1, w ^ 8'hFF, 0, 1, 1, 1 + FF_INC, "byte_err");
    gen(w);
    step(1, 1, w, 0, 1, 0, 1 + FF_INC, "after_byte");

    gen(w);
    step(1, 1, w, 1, 1, 0, 0, "clr");
    for (int j = 1; j <= 4; j++) begin
      gen(w);
      step(1, 1, w ^ 8'h01, 0, j < 4, 1, j, "burst");
    end
    for (int k = 1; k <= 12; k++) begin
      gen(w);
      step(1, 1, w, 0, k == 12, 0, 4, "relock");
    end

    gen(w);
    step(1, 1, w ^ 8'h01, 1, 1, 1, 1, "clr_and_err");
    gen(w);
    step(1, 1, w, 0, 1, 0, 1, "after_clr_err");

    for (int j = 2; j <= 16; j++) begin
      gen(w);
      step(1, 1, w ^ 8'h01, 0, 1, 1, (j > 15) ? 15 : j, "saturate");
      gen(w);
      step(1, 1, w, 0, 1, 0, (j > 15) ? 15 : j, "sat_clean");
    end

    gen(w);
    step(0, 1, w, 0, 0, 0, 0, "mid_rst");
    for (int k = 1; k <= 12; k++) begin
      gen(w);
      step(1, 1, w, 0, k == 12, 0, 0, "gap_lock");
      if (k < 12) begin
        for (int q = 0; q < 3; q++) step(1, 0, 8'hA5, 0, 0, 0, 0, "gap_idle");
      end
    end

    step(0, 0, 8'h00, 0, 0, 0, 0, "rst_zero");
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 8'h00, 0, 0, 0, 0, "zeros");
    end

    data_valid = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
